countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 100000000, meaning clk cycles per displayed second, legal range 2..2^27.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that loads load_bcd and begins counting.
REQ-005 The block SHALL have port cancel, input, 1 bit: a one-cycle pulse that aborts counting.
REQ-006 The block SHALL have port load_bcd, input, 8 bits: start value, {tens, ones} BCD, 00..99.
REQ-007 The block SHALL have port seconds, output, 9 bits: bit8 = countdown active, [7:0] = current BCD value; it feeds the display stage directly.
REQ-008 The block SHALL have port expired, output, 1 bit: a one-cycle pulse when the countdown completes.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in RUN.

Function
REQ-010 The block SHALL implement the states IDLE, RUN and EXPIRE.
REQ-011 In IDLE, start=1 and cancel=0 SHALL load value, clear the prescaler and enter RUN on the next edge.
REQ-012 Each load digit >9 SHALL be clamped to 9 at load, so 8'hA5 loads 95 and 8'h3F loads 39.
REQ-013 In RUN, the prescaler SHALL count 0..TICKS_PER_SEC-1 and assert an internal tick on the terminal count, then wrap to 0.
REQ-014 On tick with value != 00, value SHALL BCD-decrement: if ones=0, ones becomes 9 and tens decrements; otherwise ones decrements.
REQ-015 On tick with value = 00, the state SHALL go to EXPIRE; N loaded therefore takes (N+1)*TICKS_PER_SEC cycles from the start edge to EXPIRE.
REQ-016 EXPIRE SHALL last exactly one cycle with expired=1, then return to IDLE; value SHALL stay 00.
REQ-017 seconds[8] SHALL be 1 in RUN and EXPIRE and 0 in IDLE; seconds[7:0] SHALL always show the registered value.
REQ-018 start in RUN or EXPIRE SHALL reload the value, clear the prescaler and remain in or enter RUN; expired SHALL NOT pulse in that case.
REQ-019 cancel in any state SHALL force IDLE with value 00 on the next edge; when start and cancel are asserted together, cancel SHALL win.
REQ-020 A tick coinciding with start SHALL be discarded; the reload takes priority.
REQ-021 All outputs SHALL be registered, with no combinational path from an input to an output.

Reset
REQ-022 While reset=1, the state SHALL be IDLE, the prescaler 0, value 00, seconds 9'h000, expired 0 and busy 0, independent of clk.
REQ-023 Reset asserted mid-RUN SHALL abandon the count; no expired pulse SHALL be produced.
REQ-024 After reset is released, the first start SHALL be honoured on the first clk edge.

Configuration
REQ-025 When COUNTDOWN_PAUSE_EN is defined, the block SHALL add input pause (1 bit); while pause=1 in RUN, the prescaler and value SHALL freeze, with busy and seconds[8] held at 1.
REQ-026 When COUNTDOWN_PAUSE_EN is defined, start and cancel SHALL still act while paused.
REQ-027 When COUNTDOWN_PAUSE_EN is undefined, the pause port and its logic SHALL be absent, and behaviour SHALL be as if pause=0.

Structure
REQ-028 A shared package timer_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, EXPIRE=2'd2), the constant SEC_ACTIVE_BIT=8 and the BCD digit max 4'd9.
REQ-029 The BCD decrement and clamp logic SHALL live in one sub-module, bcd2_down, which is combinational: 8-bit BCD in, 8-bit BCD out, plus a zero flag.
REQ-030 The prescaler width SHALL be $clog2(TICKS_PER_SEC) bits, held inside countdown_timer.

Verification (bench uses TICKS_PER_SEC=4)
REQ-031 Start with load_bcd=8'h03: seconds SHALL read 1_03, 1_02, 1_01 and 1_00, each for 4 cycles, then expired SHALL pulse once at cycle 16, and seconds SHALL read 0_00 from cycle 17.
REQ-032 Start with 8'h10: after 4 cycles, seconds[7:0] SHALL step 10 -> 09, checking the tens borrow.
REQ-033 Start with 8'hA5: the loaded value SHALL be 95, clamped.
REQ-034 Start with 8'h50, then start with 8'h02 at cycle 6: the value SHALL reload to 02, the prescaler SHALL restart, and expired SHALL come 12 cycles later.
REQ-035 Assert start and cancel together during RUN: the next state SHALL be IDLE with seconds=0, and expired SHALL never pulse.
REQ-036 Assert reset asynchronously mid-RUN between clk edges: outputs SHALL clear immediately, and the first start after release SHALL count normally.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the countdown timer: state encoding,
//               the bit position of the "active" flag in the seconds output,
//               and the BCD digit limit with its clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] EXPIRE = 2'd2;

  localparam int SEC_ACTIVE_BIT = 8;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Saturate a single BCD digit to 9 so out-of-range loads stay displayable.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_down.sv
`default_nettype none
// ============================================================================
// Module      : bcd2_down
// Description : Combinational two-digit BCD helper. In load mode it clamps
//               each digit to 9; otherwise it returns the input decremented
//               by one (00 stays at 00). o_zero flags an input of 00.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2_down
  import timer_pkg::*;
(
  input  logic       i_load,
  input  logic [7:0] i_bcd,
  output logic [7:0] o_bcd,
  output logic       o_zero
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  assign w_tens = i_bcd[7:4];
  assign w_ones = i_bcd[3:0];
  assign o_zero = (i_bcd == 8'h00);

  // Clamp on load, otherwise decrement with a borrow from tens into ones.
  always_comb begin
    o_bcd = i_bcd;
    if (i_load) begin
      o_bcd = {bcd_clamp(w_tens), bcd_clamp(w_ones)};
    end else if (w_ones == 4'd0) begin
      if (w_tens != 4'd0) begin
        o_bcd = {w_tens - 4'd1, BCD_DIGIT_MAX};
      end else begin
        o_bcd = 8'h00;
      end
    end else begin
      o_bcd = {w_tens, w_ones - 4'd1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Two-digit BCD seconds countdown. start loads a value (digits
//               clamped to 9) and counts down once per TICKS_PER_SEC cycles;
//               after 00 has been shown for a full second, expired pulses for
//               one cycle. cancel aborts and wins over start.
//               Optional macro COUNTDOWN_PAUSE_EN adds a pause input that
//               freezes the prescaler and value while counting.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic [7:0] load_bcd,
`ifdef COUNTDOWN_PAUSE_EN
  input  logic       pause,
`endif
  output logic [8:0] seconds,
  output logic       expired,
  output logic       busy
);

  localparam int               PRESC_W    = $clog2(TICKS_PER_SEC);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PRESC_W-1:0] r_presc;
  logic [7:0]         r_value;
  logic               r_active;
  logic               r_busy;
  logic               r_expired;

  logic               w_pause;
  logic               w_tick;
  logic [7:0]         w_bcd_in;
  logic [7:0]         w_bcd_out;
  logic               w_zero;
  logic               w_active_nxt;
  logic               w_busy_nxt;
  logic               w_expired_nxt;

`ifdef COUNTDOWN_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // A paused counter never reaches its terminal count.
  assign w_tick = (r_state == RUN) && !w_pause && (r_presc == PRESC_LAST);

  // One shared BCD unit: clamps the load value on start, else decrements.
  assign w_bcd_in = start ? load_bcd : r_value;

  bcd2_down u_bcd (
    .i_load (start),
    .i_bcd  (w_bcd_in),
    .o_bcd  (w_bcd_out),
    .o_zero (w_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: cancel beats start, start beats the tick.
  always_comb begin
    w_state_nxt = r_state;
    if (cancel) begin
      w_state_nxt = IDLE;
    end else if (start) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        RUN:     w_state_nxt = (w_tick && w_zero) ? EXPIRE : RUN;
        EXPIRE:  w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output decode from the next state so the flags can be registered.
  always_comb begin
    w_active_nxt  = (w_state_nxt != IDLE);
    w_busy_nxt    = (w_state_nxt == RUN);
    w_expired_nxt = (w_state_nxt == EXPIRE);
  end

  // Prescaler, BCD value and registered output flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_value   <= 8'h00;
      r_active  <= 1'b0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_active  <= w_active_nxt;
      r_busy    <= w_busy_nxt;
      r_expired <= w_expired_nxt;
      if (cancel) begin
        r_presc <= '0;
        r_value <= 8'h00;
      end else if (start) begin
        r_presc <= '0;
        r_value <= w_bcd_out;
      end else if ((r_state == RUN) && !w_pause) begin
        if (w_tick) begin
          r_presc <= '0;
          if (!w_zero) begin
            r_value <= w_bcd_out;
          end
        end else begin
          r_presc <= r_presc + PRESC_W'(1);
        end
      end
    end
  end

  assign seconds[SEC_ACTIVE_BIT]     = r_active;
  assign seconds[SEC_ACTIVE_BIT-1:0] = r_value;
  assign expired                     = r_expired;
  assign busy                        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer with TICKS_PER_SEC=4.
//               A cycle-count model predicts seconds/expired/busy every cycle;
//               directed sequences pin literal values; random start/cancel
//               traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic [7:0] load_bcd = 8'h00;
  logic [8:0] seconds;
  logic       expired;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  countdown_timer #(.TICKS_PER_SEC(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cancel   (cancel),
    .load_bcd (load_bcd),
    .seconds  (seconds),
    .expired  (expired),
    .busy     (busy)
  );

  // Model: mode 0 = idle, 1 = counting, 2 = expired cycle.
  // While counting, m_cnt is the number of edges since the start edge; the
  // displayed value is n - cnt/T and expiry comes at cnt = (n+1)*T.
  int m_mode = 0;
  int m_n    = 0;
  int m_cnt  = 0;

  function automatic int load_value(input logic [7:0] v);
    int t;
    int o;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  function automatic logic [8:0] exp_seconds();
    int v;
    if (m_mode == 0) return 9'h000;
    if (m_mode == 2) return 9'h100;
    v = m_n - m_cnt / T;
    return {1'b1, 4'(v / 10), 4'(v % 10)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0;
      m_n    = 0;
      m_cnt  = 0;
    end else if (cancel) begin
      m_mode = 0;
    end else if (start) begin
      m_mode = 1;
      m_n    = load_value(load_bcd);
      m_cnt  = 0;
    end else if (m_mode == 1) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == (m_n + 1) * T) m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    n_checks++;
    if (seconds !== exp_seconds() || expired !== (m_mode == 2) || busy !== (m_mode == 1)) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: got seconds=%h expired=%b busy=%b, required seconds=%h expired=%b busy=%b",
               $time, seconds, expired, busy, exp_seconds(), (m_mode == 2), (m_mode == 1));
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] v);
    start    = 1'b1;
    load_bcd = v;
    step();
    start    = 1'b0;
  endtask

  int n_exp;

  initial begin
    // Reset state.
    #12;
    chk("reset_seconds", int'(seconds), 'h000);
    chk("reset_expired", int'(expired), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // 03 counts 03..00, four cycles each, expires on edge 16, idle at 17.
    do_start(8'h03);
    for (int i = 0; i < 18; i++) begin
      if (i > 0) step();
      if (i < 16) chk("cnt03_seconds", int'(seconds), 'h100 + (3 - i / 4));
      else if (i == 16) chk("cnt03_seconds", int'(seconds), 'h100);
      else chk("cnt03_seconds", int'(seconds), 'h000);
      chk("cnt03_expired", int'(expired), (i == 16) ? 1 : 0);
    end

    // Tens borrow: 10 -> 09 after four cycles.
    do_start(8'h10);
    chk("borrow_pre", int'(seconds), 'h110);
    repeat (3) step();
    chk("borrow_hold", int'(seconds), 'h110);
    step();
    chk("borrow_step", int'(seconds), 'h109);

    // Clamp: A5 loads as 95, 3F as 39.
    do_start(8'hA5);
    chk("clamp_A5", int'(seconds), 'h195);
    do_start(8'h3F);
    chk("clamp_3F", int'(seconds), 'h139);

    // Reload mid-count: start 50, then start 02 on edge 6; expires 12 later.
    do_start(8'h50);
    repeat (5) step();
    do_start(8'h02);
    chk("reload_val", int'(seconds), 'h102);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("reload_expired", int'(expired), (k == 12) ? 1 : 0);
    end

    // start and cancel together: cancel wins, no expiry afterwards.
    do_start(8'h20);
    repeat (3) step();
    start    = 1'b1;
    cancel   = 1'b1;
    load_bcd = 8'h77;
    step();
    start  = 1'b0;
    cancel = 1'b0;
    chk("cancel_seconds", int'(seconds), 'h000);
    chk("cancel_busy", int'(busy), 0);
    n_exp = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (expired === 1'b1) n_exp++;
    end
    chk("cancel_no_expire", n_exp, 0);

    // Tick on 00 coinciding with start: reload wins, no expiry.
    do_start(8'h00);
    repeat (3) step();
    do_start(8'h01);
    chk("tick_start_val", int'(seconds), 'h101);
    chk("tick_start_noexp", int'(expired), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("tick_start_expired", int'(expired), (k == 8) ? 1 : 0);
    end
    // Start during the expired cycle re-enters counting without a new pulse.
    do_start(8'h02);
    chk("exp_restart_val", int'(seconds), 'h102);
    chk("exp_restart_busy", int'(busy), 1);
    chk("exp_restart_noexp", int'(expired), 0);

    // Asynchronous reset mid-count clears outputs between edges.
    do_start(8'h05);
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_seconds", int'(seconds), 'h000);
    chk("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    do_start(8'h01);
    chk("post_rst_val", int'(seconds), 'h101);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_rst_expired", int'(expired), (k == 8) ? 1 : 0);
    end

    // Random start/cancel traffic, checked by the model every cycle.
    for (int k = 0; k < 4000; k++) begin
      start  = ($urandom_range(0, 29) == 0);
      cancel = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 3) == 0) load_bcd = 8'($urandom);
      else load_bcd = 8'($urandom_range(0, 5));
      step();
    end
    start  = 1'b0;
    cancel = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
